// File: rtl/pe_psum_accum.sv
// PE partial-sum stage: NCH signed accumulators seeded from zero or an upstream psum,
// optional saturation, and a 1-entry valid/ready result register with a forward bypass.

module pe_psum_lane #(
    parameter int DWD = 24
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           hit,
    input  logic           first,
    input  logic           last,
    input  logic           zero,
    input  logic [DWD-1:0] res,
    output logic [DWD-1:0] acc,
    output logic           busy
);
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            acc  <= '0;
            busy <= 1'b0;
        end else if (hit) begin
            if (last) begin
                acc  <= '0;
                busy <= 1'b0;
            end else begin
                // a zero beat in mid-psum leaves the value unchanged, so skip the write
                if (!(zero && !first)) acc <= res;
                busy <= 1'b1;
            end
        end
    end
endmodule

module pe_psum_accum #(
    parameter int AU_OD_WD = 16,
    parameter int DWD      = 24,
    parameter int NCH      = 4,
    parameter int SAT      = 1,
    parameter int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_cont_reset,
    input  logic                       i_cont_stall,
    input  logic                       i_cont_read_psum,
    input  logic                       i_cont_forward,
    input  logic                       i_sum_valid,
    output logic                       o_sum_ready,
    input  logic signed [AU_OD_WD-1:0] i_sum,
    input  logic                       i_sum_zero,
    input  logic [CHW-1:0]             i_sum_ch,
    input  logic                       i_sum_first,
    input  logic                       i_sum_last,
    input  logic                       i_psum_valid,
    output logic                       o_psum_in_ready,
    input  logic signed [DWD-1:0]      i_psum,
    input  logic [CHW-1:0]             i_psum_ch,
    output logic                       o_psum_valid,
    input  logic                       i_psum_ready,
    output logic signed [DWD-1:0]      o_psum,
    output logic [CHW-1:0]             o_psum_ch,
    output logic [NCH-1:0]             o_busy,
    output logic                       o_sat
);
    localparam logic [DWD-1:0] MAX_V = {1'b0, {(DWD-1){1'b1}}};
    localparam logic [DWD-1:0] MIN_V = {1'b1, {(DWD-1){1'b0}}};

    logic                     slot_ok, fire, fwd_fire, ovf;
    logic [NCH-1:0][DWD-1:0]  acc_q;
    logic [DWD-1:0]           acc_sel, base, res;
    logic [DWD:0]             add, sum_w;

    assign slot_ok     = !o_psum_valid || i_psum_ready;
    assign o_sum_ready = !i_cont_reset && !i_cont_forward && !i_cont_stall && slot_ok &&
                         (!i_cont_read_psum || i_psum_valid);
    assign fire        = i_sum_valid && o_sum_ready;
    assign o_psum_in_ready = !i_cont_reset &&
                             (i_cont_forward ? (!i_cont_stall && slot_ok)
                                             : (fire && i_sum_first && i_cont_read_psum));
    assign fwd_fire    = i_cont_forward && i_psum_valid && o_psum_in_ready;

    // explicit compare keeps out-of-range channel codes (NCH not a power of 2) reading zero
    always_comb begin
        acc_sel = '0;
        for (int i = 0; i < NCH; i++)
            if (i_sum_ch == CHW'(i)) acc_sel = acc_q[i];
    end

    always_comb begin
        base  = i_sum_first ? (i_cont_read_psum ? i_psum : '0) : acc_sel;
        add   = i_sum_zero ? '0 : {{(DWD+1-AU_OD_WD){i_sum[AU_OD_WD-1]}}, i_sum};
        sum_w = {base[DWD-1], base} + add;
        ovf   = sum_w[DWD] != sum_w[DWD-1];
        res   = sum_w[DWD-1:0];
        if (SAT != 0 && ovf) res = sum_w[DWD] ? MIN_V : MAX_V;
    end

    for (genvar g = 0; g < NCH; g++) begin : g_lane
        pe_psum_lane #(.DWD(DWD)) u_lane (
            .clk   (i_clk),
            .rst_n (i_rst_n),
            .clr   (i_cont_reset),
            .hit   (fire && (i_sum_ch == CHW'(g))),
            .first (i_sum_first),
            .last  (i_sum_last),
            .zero  (i_sum_zero),
            .res   (res),
            .acc   (acc_q[g]),
            .busy  (o_busy[g])
        );
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_cont_reset) begin
            o_psum_valid <= 1'b0;
            o_psum       <= '0;
            o_psum_ch    <= '0;
            o_sat        <= 1'b0;
        end else begin
            if (fire && i_sum_last) begin
                o_psum_valid <= 1'b1;
                o_psum       <= res;
                o_psum_ch    <= i_sum_ch;
            end else if (fwd_fire) begin
                o_psum_valid <= 1'b1;
                o_psum       <= i_psum;
                o_psum_ch    <= i_psum_ch;
            end else if (i_psum_ready) begin
                o_psum_valid <= 1'b0;
            end
            if (SAT != 0 && fire && ovf) o_sat <= 1'b1;
        end
    end
endmodule
